// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_AW    = 4;
  localparam int DMEM_DW    = 16;
  localparam int DMEM_DEPTH = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_WR   = 3'd1,
    CPU_WR  = 3'd2,
    CPU_RD  = 3'd3,
    CPU_RSP = 3'd4
  } dmem_state_e;

  typedef enum logic [1:0] {
    RID_NONE = 2'd0,
    RID_LD   = 2'd1,
    RID_CPU  = 2'd2
  } dmem_rid_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the boot loader and the CPU MEM stage onto one memory port.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of loader-first priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW    = DMEM_AW,
  parameter int DW    = DMEM_DW,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          ld_gnt,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] load_cnt,
  output logic          load_done
);

  dmem_state_e state_r;
  dmem_state_e state_nxt_s;
  dmem_rid_e   grant_s;
  logic        ld_ok_s;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return (int'(addr) < DEPTH);
  endfunction

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr_r;  // 1: CPU wins the next tie

  function automatic dmem_rid_e arbitrate(input logic ld_ok, input logic cpu_ok,
                                          input logic cpu_fav);
    dmem_rid_e rid;
    if (ld_ok && cpu_ok) begin
      rid = cpu_fav ? RID_CPU : RID_LD;
    end else if (ld_ok) begin
      rid = RID_LD;
    end else if (cpu_ok) begin
      rid = RID_CPU;
    end else begin
      rid = RID_NONE;
    end
    return rid;
  endfunction
`else
  function automatic dmem_rid_e arbitrate(input logic ld_ok, input logic cpu_ok);
    dmem_rid_e rid;
    if (ld_ok) begin
      rid = RID_LD;
    end else if (cpu_ok) begin
      rid = RID_CPU;
    end else begin
      rid = RID_NONE;
    end
    return rid;
  endfunction
`endif

  // Loader is locked out once the image is complete.
  assign ld_ok_s = ld_req && !load_done;

  // Next-state decode; requests are only looked at from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = RID_NONE;
    if (state_r == IDLE) begin
`ifdef DMEM_ARB_RR_EN
      grant_s = arbitrate(ld_ok_s, cpu_req, rr_ptr_r);
`else
      grant_s = arbitrate(ld_ok_s, cpu_req);
`endif
    end else begin
      grant_s = RID_NONE;
    end
    case (state_r)
      IDLE: begin
        case (grant_s)
          RID_LD:  state_nxt_s = LD_WR;
          RID_CPU: state_nxt_s = cpu_we ? CPU_WR : CPU_RD;
          default: state_nxt_s = IDLE;
        endcase
      end
      LD_WR:   state_nxt_s = IDLE;
      CPU_WR:  state_nxt_s = IDLE;
      CPU_RD:  state_nxt_s = CPU_RSP;
      CPU_RSP: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: favour whoever was not granted last.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rr_ptr_r <= 1'b0;
    end else if (grant_s == RID_LD) begin
      rr_ptr_r <= 1'b1;
    end else if (grant_s == RID_CPU) begin
      rr_ptr_r <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // Registered handshakes and memory port; the port regs double as the payload latch.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ld_gnt     <= 1'b0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= {DW{1'b0}};
      mem_we     <= 1'b0;
      mem_addr   <= {AW{1'b0}};
      mem_wdata  <= {DW{1'b0}};
    end else begin
      ld_gnt     <= (state_nxt_s == LD_WR);
      cpu_gnt    <= (state_nxt_s == CPU_WR) || (state_nxt_s == CPU_RD);
      cpu_rvalid <= (state_nxt_s == CPU_RSP);
      if (grant_s == RID_LD) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_wdata;
        mem_we    <= in_range(ld_addr);
      end else if (grant_s == RID_CPU) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_we && in_range(cpu_addr);
      end else begin
        mem_we    <= 1'b0;
      end
      // Out-of-range reads return zero rather than whatever the array drives.
      if (state_r == CPU_RD) begin
        cpu_rdata <= in_range(mem_addr) ? mem_rdata : {DW{1'b0}};
      end else begin
        cpu_rdata <= cpu_rdata;
      end
    end
  end

  // Loader progress: count grants up to DEPTH, done flag follows one cycle later.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      load_cnt  <= {AW{1'b0}};
      load_done <= 1'b0;
    end else begin
      if (ld_gnt && (load_cnt != AW'(DEPTH))) begin
        load_cnt <= load_cnt + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        load_cnt <= load_cnt;
      end
      load_done <= load_done || (load_cnt == AW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver pushes expectations, negedge monitor pops and checks.
module tb_dmem_arbiter;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 10;
  localparam int ID_LD = 1;
  localparam int ID_CPU = 2;

  logic clk, clr;
  logic ld_req, cpu_req, cpu_we;
  logic [AW-1:0] ld_addr, cpu_addr, mem_addr, load_cnt;
  logic [DW-1:0] ld_wdata, cpu_wdata, mem_rdata, cpu_rdata, mem_wdata;
  logic ld_gnt, cpu_gnt, cpu_rvalid, mem_we, load_done;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_rdata(mem_rdata),
    .ld_gnt(ld_gnt), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_cnt(load_cnt), .load_done(load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory array; out-of-range reads drive junk the DUT must mask.
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (mem_we && (int'(mem_addr) < DEPTH)) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = (int'(mem_addr) < DEPTH) ? mem[mem_addr] : 16'hDEAD;

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int ld_issued = 0;
  int fav = ID_LD;

  typedef struct { int rid; int cyc; } gnt_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
  typedef struct { logic [DW-1:0] data; int cyc; } rd_t;
  gnt_t gnt_q[$];
  wr_t  wr_q[$];
  rd_t  rd_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int ld_gnt_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record what the arbiter must do for one granted request, in grant order.
  task automatic expect_issue(input int rid, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int gcyc);
    gnt_q.push_back('{rid, gcyc});
    fav = (rid == ID_LD) ? ID_CPU : ID_LD;
    if (rid == ID_LD) ld_issued++;
    if (rid == ID_LD || we) begin
      if (int'(a) < DEPTH) begin
        wr_q.push_back('{a, d, gcyc});
        ref_mem[a] = d;
      end
    end else begin
      rd_q.push_back('{(int'(a) < DEPTH) ? ref_mem[a] : 16'h0000, (gcyc < 0) ? -1 : gcyc + 1});
    end
  endtask

  // Monitor: every DUT handshake must match the head of its queue.
  always @(negedge clk) begin
    gnt_t g;
    wr_t w;
    rd_t r;
    if (!clr) begin
      if (ld_gnt) ld_gnt_seen++;
      if (ld_gnt || cpu_gnt) begin
        if (ld_gnt && cpu_gnt) check("gnt_both", 2'b11, 2'b01);
        if (gnt_q.size() == 0) begin
          check("unexpected_gnt", {ld_gnt, cpu_gnt}, 2'b00);
        end else begin
          g = gnt_q.pop_front();
          check("gnt_who", ld_gnt ? ID_LD : ID_CPU, g.rid);
          if (g.cyc >= 0) check("gnt_cycle", cyc, g.cyc);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_mem_we", {mem_addr, mem_wdata}, 0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_wdata, w.data);
          if (w.cyc >= 0) check("wr_cycle", cyc, w.cyc);
        end
      end
      if (cpu_rvalid) begin
        if (rd_q.size() == 0) begin
          check("unexpected_rvalid", cpu_rdata, 0);
        end else begin
          r = rd_q.pop_front();
          check("rd_data", cpu_rdata, r.data);
          if (r.cyc >= 0) check("rd_cycle", cyc, r.cyc);
        end
      end
    end
  end

  // Called just after a posedge; drops each request the cycle after its grant.
  task automatic wait_gnts(input logic want_ld, input logic want_cpu);
    logic got_ld = 1'b0;
    logic got_cpu = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ((got_ld || !want_ld) && (got_cpu || !want_cpu)) break;
      @(negedge clk);
      if (ld_gnt) got_ld = 1'b1;
      if (cpu_gnt) got_cpu = 1'b1;
      @(posedge clk);
      #1;
      if (got_ld) ld_req = 1'b0;
      if (got_cpu) cpu_req = 1'b0;
    end
    check("gnt_arrived", {got_ld, got_cpu}, {want_ld, want_cpu});
    ld_req = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_ld();
    logic [AW-1:0] a = AW'(ld_issued);
    logic [DW-1:0] d = 16'h00A0 + DW'(ld_issued);
    ld_req = 1'b1; ld_addr = a; ld_wdata = d;
    expect_issue(ID_LD, 1'b1, a, d, cyc + 1);
    wait_gnts(1'b1, 1'b0);
    check("load_cnt", load_cnt, (ld_issued > DEPTH) ? DEPTH : ld_issued);
    check("load_done", load_done, ld_issued >= DEPTH);
  endtask

  task automatic do_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    expect_issue(ID_CPU, we, a, d, cyc + 1);
    wait_gnts(1'b0, 1'b1);
  endtask

  task automatic do_pair(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [AW-1:0] la = AW'(ld_issued);
    logic [DW-1:0] ldd = 16'h00A0 + DW'(ld_issued);
    int first;
    int c;
`ifdef DMEM_ARB_RR_EN
    first = fav;
`else
    first = ID_LD;
`endif
    ld_req = 1'b1; ld_addr = la; ld_wdata = ldd;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    c = cyc;
    if (first == ID_LD) begin
      expect_issue(ID_LD, 1'b1, la, ldd, c + 1);
      expect_issue(ID_CPU, we, a, d, -1);
    end else begin
      expect_issue(ID_CPU, we, a, d, c + 1);
      expect_issue(ID_LD, 1'b1, la, ldd, -1);
    end
    wait_gnts(1'b1, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ld_gnt"}, ld_gnt, 1'b0);
    check({tag, "_cpu_gnt"}, cpu_gnt, 1'b0);
    check({tag, "_rvalid"}, cpu_rvalid, 1'b0);
    check({tag, "_rdata"}, cpu_rdata, 16'h0000);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_load_cnt"}, load_cnt, 4'd0);
    check({tag, "_load_done"}, load_done, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic got;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    clr = 1'b1; ld_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    ld_addr = '0; ld_wdata = '0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_mem_addr", mem_addr, 4'd0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Directed store/load and out-of-range accesses
    do_cpu(1'b1, 4'd3, 16'hBEEF);
    do_cpu(1'b0, 4'd3, 16'h0000);
    do_cpu(1'b0, 4'd12, 16'h0000);
    do_cpu(1'b1, 4'd12, 16'h1234);
    do_cpu(1'b0, 4'd15, 16'h0000);

    // Arbitration: a loader-only grant first so round-robin favours the CPU next
    do_ld();
    for (int i = 0; i < 4; i++)
      do_pair(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    while (ld_issued < DEPTH) do_ld();

    // Loader locked out after load_done
    seen = ld_gnt_seen;
    ld_req = 1'b1; ld_addr = 4'd1; ld_wdata = 16'h5555;
    repeat (8) @(posedge clk);
    #1;
    ld_req = 1'b0;
    check("no_gnt_after_done", ld_gnt_seen, seen);
    check("load_cnt_sat", load_cnt, DEPTH);

    // Randomised CPU traffic including out-of-range addresses
    for (int i = 0; i < 30; i++)
      do_cpu(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));

    // Reset while in CPU_RD aborts the read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    gnt_q.push_back('{ID_CPU, cyc + 1});
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = cpu_gnt;
    end
    check("rd_gnt_before_clr", got, 1'b1);
    #2;
    clr = 1'b1;
    cpu_req = 1'b0;
    ld_issued = 0;
    fav = ID_LD;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    check_idle_outputs("midrd");
    repeat (4) @(posedge clk);
    #1;
    check("post_clr_rdata", cpu_rdata, 16'h0000);
    check("post_clr_load_cnt", load_cnt, 4'd0);

    // FSM back in IDLE: next request granted with nominal latency
    do_ld();
    do_pair(1'b0, 4'd0, 16'h0000);
    do_ld();

    repeat (5) @(posedge clk);
    #1;
    check("gnt_q_drained", gnt_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
